// File: rtl/v_fifo_hs.sv
// rtl/v_fifo_hs.sv - width-converting vector FIFO with valid/ready on both sides; optional replay via VFIFO_REPLAY_EN
module v_fifo_hs #(
    parameter int VecElements      = 4,
    parameter int ElementsPerWrite = 2,
    parameter int ElementsPerRead  = 4,
    parameter int NBits            = 8,
    parameter int Depth            = 2
) (
    input  logic                                          clk_in,
    input  logic                                          rst_in,
    input  logic                                          wr_valid,
    output logic                                          wr_ready,
    input  logic [ElementsPerWrite-1:0][NBits-1:0]        wr_data,
    output logic                                          rd_valid,
    input  logic                                          rd_ready,
    output logic [ElementsPerRead-1:0][NBits-1:0]         rd_data,
    output logic                                          rd_last,
    input  logic                                          hold_vec,
    input  logic                                          rewind,
    output logic [$clog2(Depth*VecElements+1)-1:0]        count,
    output logic                                          full,
    output logic                                          empty
);

    localparam int C    = Depth * VecElements;
    localparam int EPW  = ElementsPerWrite;
    localparam int EPR  = ElementsPerRead;
    localparam int PtrW = (C > 1) ? $clog2(C) : 1;
    localparam int OffW = $clog2(VecElements + 1);
    localparam int CntW = $clog2(C + 1);

    logic [NBits-1:0] mem [C];
    logic [PtrW-1:0]  wr_ptr, wr_ptr_nxt;
    logic [PtrW-1:0]  rd_ptr, rd_ptr_nxt;
    logic [OffW-1:0]  rd_off, rd_off_nxt;
    logic [CntW-1:0]  count_q, count_nxt;
    logic             wr_fire, rd_fire;
    int               freed;

    // Pointers are element indices that wrap at C; chunks are aligned so no straddling.
    function automatic logic [PtrW-1:0] ptr_add(input logic [PtrW-1:0] p, input int n);
        int s;
        s = int'(p) + n;
        if (s >= C) s = s - C;
        return PtrW'(s);
    endfunction

    assign wr_ready = (count_q <= CntW'(C - EPW));
    assign full     = !wr_ready;
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign rd_last  = ((int'(rd_off) + EPR) == VecElements);

`ifdef VFIFO_REPLAY_EN
    // Elements of the vector being read stay counted until the vector is released.
    assign rd_valid = ((int'(count_q) - int'(rd_off)) >= EPR);
`else
    assign rd_valid = (int'(count_q) >= EPR);
    logic unused_replay;
    assign unused_replay = hold_vec ^ rewind;
`endif

    assign wr_fire = wr_valid & wr_ready;
    assign rd_fire = rd_valid & rd_ready;

    // Next-state for pointers, vector offset and occupancy.
    always_comb begin
        wr_ptr_nxt = wr_fire ? ptr_add(wr_ptr, EPW) : wr_ptr;
        rd_ptr_nxt = rd_ptr;
        rd_off_nxt = rd_off;
        freed      = 0;
`ifdef VFIFO_REPLAY_EN
        if (rewind) begin
            // Vectors are aligned in storage, so the base never goes below zero.
            rd_ptr_nxt = PtrW'(int'(rd_ptr) - int'(rd_off));
            rd_off_nxt = '0;
        end else if (rd_fire) begin
            if (rd_last && hold_vec) begin
                rd_ptr_nxt = PtrW'(int'(rd_ptr) - int'(rd_off));
                rd_off_nxt = '0;
            end else if (rd_last) begin
                rd_ptr_nxt = ptr_add(rd_ptr, EPR);
                rd_off_nxt = '0;
                freed      = VecElements;
            end else begin
                rd_ptr_nxt = ptr_add(rd_ptr, EPR);
                rd_off_nxt = rd_off + OffW'(EPR);
            end
        end
`else
        if (rd_fire) begin
            rd_ptr_nxt = ptr_add(rd_ptr, EPR);
            rd_off_nxt = rd_last ? '0 : rd_off + OffW'(EPR);
            freed      = EPR;
        end
`endif
        count_nxt = CntW'(int'(count_q) + (wr_fire ? EPW : 0) - freed);
    end

    // State registers; reset discards contents but leaves storage untouched.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            rd_off  <= '0;
            count_q <= '0;
        end else begin
            wr_ptr  <= wr_ptr_nxt;
            rd_ptr  <= rd_ptr_nxt;
            rd_off  <= rd_off_nxt;
            count_q <= count_nxt;
        end
    end

    // Element storage; writes during the reset cycle are dropped.
    always_ff @(posedge clk_in) begin
        if (rst_in && wr_fire) begin
            for (int i = 0; i < EPW; i++) begin
                mem[ptr_add(wr_ptr, i)] <= wr_data[i];
            end
        end
    end

    // Read chunk presented straight from storage at rd_ptr.
    always_comb begin
        for (int i = 0; i < EPR; i++) begin
            rd_data[i] = mem[ptr_add(rd_ptr, i)];
        end
    end

endmodule

// File: tb/tb_v_fifo_hs.sv
// tb/tb_v_fifo_hs.sv - scoreboard bench for v_fifo_hs
module tb_v_fifo_hs;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [1:0][7:0] wr_data = '0;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic [3:0][7:0] rd_data;
    logic        rd_last;
    logic        hold_vec = 1'b0;
    logic        rewind = 1'b0;
    logic [3:0]  count;
    logic        full;
    logic        empty;

    int checks = 0;
    int errors = 0;
    int n_reads = 0;
    logic [7:0] exp_q[$];
    logic [31:0] exp_chunk;

    always #5 clk_in = ~clk_in;

    v_fifo_hs #(
        .VecElements(4), .ElementsPerWrite(2), .ElementsPerRead(4), .NBits(8), .Depth(2)
    ) u_dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .hold_vec(hold_vec), .rewind(rewind),
        .count(count), .full(full), .empty(empty)
    );

`ifdef VFIFO_REPLAY_EN
    logic        r_wr_valid = 1'b0;
    logic        r_wr_ready;
    logic [1:0][7:0] r_wr_data = '0;
    logic        r_rd_valid;
    logic        r_rd_ready = 1'b0;
    logic [1:0][7:0] r_rd_data;
    logic        r_rd_last;
    logic        r_hold = 1'b0;
    logic        r_rewind = 1'b0;
    logic [3:0]  r_count;
    logic        r_full;
    logic        r_empty;

    v_fifo_hs #(
        .VecElements(4), .ElementsPerWrite(2), .ElementsPerRead(2), .NBits(8), .Depth(2)
    ) u_rep (
        .clk_in(clk_in), .rst_in(rst_in),
        .wr_valid(r_wr_valid), .wr_ready(r_wr_ready), .wr_data(r_wr_data),
        .rd_valid(r_rd_valid), .rd_ready(r_rd_ready), .rd_data(r_rd_data), .rd_last(r_rd_last),
        .hold_vec(r_hold), .rewind(r_rewind),
        .count(r_count), .full(r_full), .empty(r_empty)
    );

    task automatic rstep(input logic wv, input logic [15:0] wd, input logic rr,
                         input logic hv, input logic rw);
        r_wr_valid = wv; r_wr_data = wd; r_rd_ready = rr; r_hold = hv; r_rewind = rw;
        @(posedge clk_in); #1;
        r_wr_valid = 1'b0; r_rd_ready = 1'b0; r_hold = 1'b0; r_rewind = 1'b0;
    endtask
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One cycle of stimulus; push records the write elements the FIFO must accept.
    task automatic step(input logic wv, input logic [15:0] wd, input logic rr, input logic push);
        wr_valid = wv; wr_data = wd; rd_ready = rr;
        if (push) begin
            chk("wr_ready_on_write", {31'd0, wr_ready}, 32'd1);
            exp_q.push_back(wd[7:0]);
            exp_q.push_back(wd[15:8]);
        end
        @(posedge clk_in); #1;
        wr_valid = 1'b0; rd_ready = 1'b0;
    endtask

    // Monitor: every read fire is compared against the oldest expected elements.
    always @(negedge clk_in) begin
        if (rst_in && rd_valid && rd_ready) begin
            if (exp_q.size() < 4) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_underflow: read fire with %0d expected elements, need 4", exp_q.size());
            end else begin
                for (int i = 0; i < 4; i++) exp_chunk[i*8 +: 8] = exp_q.pop_front();
                chk("rd_data", rd_data, exp_chunk);
                chk("rd_last", {31'd0, rd_last}, 32'd1);
                n_reads++;
            end
        end
    end

    initial begin
        rst_in = 1'b0;
        repeat (2) @(posedge clk_in);
        #1 rst_in = 1'b1;
        chk("reset_count", {28'd0, count}, 32'd0);
        chk("reset_empty", {31'd0, empty}, 32'd1);
        chk("reset_full", {31'd0, full}, 32'd0);
        chk("reset_wr_ready", {31'd0, wr_ready}, 32'd1);
        chk("reset_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("reset_rd_last", {31'd0, rd_last}, 32'd1);

        // Basic write-then-read
        step(1'b1, 16'h0201, 1'b0, 1'b1);
        chk("partial_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("partial_count", {28'd0, count}, 32'd2);
        step(1'b1, 16'h0403, 1'b0, 1'b1);
        chk("t1_rd_valid", {31'd0, rd_valid}, 32'd1);
        chk("t1_count", {28'd0, count}, 32'd4);
        chk("t1_rd_last", {31'd0, rd_last}, 32'd1);
        step(1'b0, 16'h0, 1'b1, 1'b0);
        chk("t1_empty", {31'd0, empty}, 32'd1);

        // Fill to full, then a stalled write
        step(1'b1, 16'h1110, 1'b0, 1'b1);
        step(1'b1, 16'h1312, 1'b0, 1'b1);
        step(1'b1, 16'h1514, 1'b0, 1'b1);
        step(1'b1, 16'h1716, 1'b0, 1'b1);
        chk("full_count", {28'd0, count}, 32'd8);
        chk("full_flag", {31'd0, full}, 32'd1);
        chk("full_wr_ready", {31'd0, wr_ready}, 32'd0);
        step(1'b1, 16'hEFEE, 1'b0, 1'b0);
        chk("stall_count", {28'd0, count}, 32'd8);
        step(1'b0, 16'h0, 1'b1, 1'b0);
        chk("free_wr_ready", {31'd0, wr_ready}, 32'd1);
        step(1'b0, 16'h0, 1'b1, 1'b0);
        chk("drain_count", {28'd0, count}, 32'd0);
        chk("drain_rd_valid", {31'd0, rd_valid}, 32'd0);

        // Simultaneous write and read fire at count=4
        step(1'b1, 16'h2120, 1'b0, 1'b1);
        step(1'b1, 16'h2322, 1'b0, 1'b1);
        step(1'b1, 16'h2524, 1'b1, 1'b1);
        chk("simul_count", {28'd0, count}, 32'd2);
        step(1'b1, 16'h2726, 1'b0, 1'b1);
        step(1'b0, 16'h0, 1'b1, 1'b0);
        chk("simul_empty", {31'd0, empty}, 32'd1);

        // Interleaved stream of 24 elements across pointer wraps
        for (int k = 0; k < 12; k++) begin
            step(1'b1, {8'(8'h51 + 2*k), 8'(8'h50 + 2*k)}, (k >= 3) && (k % 2 == 1), 1'b1);
        end
        chk("stream_count", {28'd0, count}, 32'd4);
        step(1'b0, 16'h0, 1'b1, 1'b0);
        chk("stream_count_end", {28'd0, count}, 32'd0);
        chk("stream_empty", {31'd0, empty}, 32'd1);

        // Reset mid-operation with count=6; the write in the reset cycle is dropped
        step(1'b1, 16'h3130, 1'b0, 1'b1);
        step(1'b1, 16'h3332, 1'b0, 1'b1);
        step(1'b1, 16'h3534, 1'b0, 1'b1);
        chk("prereset_count", {28'd0, count}, 32'd6);
        rst_in = 1'b0; wr_valid = 1'b1; wr_data = 16'hDEAD;
        @(posedge clk_in); #1;
        rst_in = 1'b1; wr_valid = 1'b0;
        exp_q.delete();
        chk("midreset_count", {28'd0, count}, 32'd0);
        chk("midreset_empty", {31'd0, empty}, 32'd1);
        chk("midreset_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("midreset_wr_ready", {31'd0, wr_ready}, 32'd1);
        step(1'b1, 16'h4140, 1'b0, 1'b1);
        step(1'b1, 16'h4342, 1'b0, 1'b1);
        step(1'b0, 16'h0, 1'b1, 1'b0);

        chk("n_reads", n_reads, 32'd12);
        chk("scoreboard_left", exp_q.size(), 32'd0);

`ifdef VFIFO_REPLAY_EN
        rstep(1'b1, 16'h0201, 1'b0, 1'b0, 1'b0);
        rstep(1'b1, 16'h0403, 1'b0, 1'b0, 1'b0);
        chk("rep_count", {28'd0, r_count}, 32'd4);
        chk("rep_chunk1", {16'd0, r_rd_data}, 32'h0201);
        chk("rep_last0", {31'd0, r_rd_last}, 32'd0);
        rstep(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        chk("rep_chunk2", {16'd0, r_rd_data}, 32'h0403);
        chk("rep_last1", {31'd0, r_rd_last}, 32'd1);
        rstep(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
        chk("rep_rewind", {16'd0, r_rd_data}, 32'h0201);
        chk("rep_rewind_off", {31'd0, r_rd_last}, 32'd0);
        rstep(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        rstep(1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
        chk("rep_hold_data", {16'd0, r_rd_data}, 32'h0201);
        chk("rep_hold_count", {28'd0, r_count}, 32'd4);
        rstep(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        rstep(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        chk("rep_free_count", {28'd0, r_count}, 32'd0);
        chk("rep_free_empty", {31'd0, r_empty}, 32'd1);
`endif

        repeat (2) @(posedge clk_in);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
